// File: rtl/dadda_seq_mul16.sv
// Four-cycle 16x16 unsigned multiplier that time-shares one 8x8 Dadda core.
// Optional macro DADDA_SEQ_ZERO_SKIP_EN: zero operands finish after one core cycle.

module dadda_core #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);
    localparam int NC = 2 * W;
    localparam int R  = W + 1;

    function automatic int dadda_d(input int k);
        int d;
        d = 2;
        for (int n = 0; n < k; n++) d = (d * 3) / 2;
        return d;
    endfunction

    function automatic int dadda_nst(input int w);
        int d;
        int n;
        d = 2;
        n = 0;
        while (d < w) begin
            n++;
            d = (d * 3) / 2;
        end
        return n;
    endfunction

    localparam int NST = dadda_nst(W);

    logic [2*W-1:0] row_a;
    logic [2*W-1:0] row_b;

    always_comb begin : reduce
        logic [R-1:0] col [NC+1];
        logic [R-1:0] nxt [NC+1];
        int           ht  [NC+1];
        int           nh  [NC+1];
        logic [R-1:0] v;
        int           t;
        int           h;
        int           rem;
        logic         s;
        logic         cy;

        v     = '0;
        t     = 0;
        h     = 0;
        rem   = 0;
        s     = 1'b0;
        cy    = 1'b0;
        row_a = '0;
        row_b = '0;
        for (int c = 0; c <= NC; c++) begin
            col[c] = '0;
            nxt[c] = '0;
            ht[c]  = 0;
            nh[c]  = 0;
        end

        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                col[i+j] = col[i+j] | (R'(a_i[i] & b_i[j]) << ht[i+j]);
                ht[i+j]  = ht[i+j] + 1;
            end
        end

        // Each stage squeezes every column down to the next Dadda height,
        // counting carries already pushed in from the column below.
        for (int st = NST - 1; st >= 0; st--) begin
            t = dadda_d(st);
            for (int c = 0; c <= NC; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < NC; c++) begin
                v   = col[c];
                rem = ht[c];
                h   = ht[c] + nh[c];
                for (int k = 0; k < R; k++) begin
                    if (h > t) begin
                        if (h == t + 1) begin
                            s   = v[0] ^ v[1];
                            cy  = v[0] & v[1];
                            v   = v >> 2;
                            rem = rem - 2;
                            h   = h - 1;
                        end else begin
                            s   = v[0] ^ v[1] ^ v[2];
                            cy  = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
                            v   = v >> 3;
                            rem = rem - 3;
                            h   = h - 2;
                        end
                        nxt[c]   = nxt[c] | (R'(s) << nh[c]);
                        nh[c]    = nh[c] + 1;
                        nxt[c+1] = nxt[c+1] | (R'(cy) << nh[c+1]);
                        nh[c+1]  = nh[c+1] + 1;
                    end
                end
                nxt[c] = nxt[c] | (v << nh[c]);
                nh[c]  = nh[c] + rem;
            end
            for (int c = 0; c <= NC; c++) begin
                col[c] = nxt[c];
                ht[c]  = nh[c];
            end
        end

        for (int c = 0; c < NC; c++) begin
            row_a[c] = col[c][0];
            row_b[c] = col[c][1];
        end
    end

    assign p_o = row_a + row_b;
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | one partial product per cycle, step 0..3
// DONE  | product held on z until the consumer takes it
module dadda_seq_mul16 #(
    parameter int HALF_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   x,
    input  logic [2*HALF_W-1:0]   y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   z,
    output logic                  busy
);
    localparam int PW = 4 * HALF_W;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           step_q, step_d;
    logic [2*HALF_W-1:0]  xr_q, xr_d;
    logic [2*HALF_W-1:0]  yr_q, yr_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [PW-1:0]        z_q, z_d;

    logic [HALF_W-1:0]    core_a;
    logic [HALF_W-1:0]    core_b;
    logic [2*HALF_W-1:0]  core_p;
    logic [PW-1:0]        pp_ext;
    logic [PW-1:0]        pp_sh;
    logic [PW-1:0]        sum;

    assign core_a = step_q[0] ? xr_q[2*HALF_W-1:HALF_W] : xr_q[HALF_W-1:0];
    assign core_b = step_q[1] ? yr_q[2*HALF_W-1:HALF_W] : yr_q[HALF_W-1:0];

    dadda_core #(.W(HALF_W)) u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

    assign pp_ext = {{(2*HALF_W){1'b0}}, core_p};

    always_comb begin
        pp_sh = pp_ext;
        case (step_q)
            2'd1, 2'd2: pp_sh = pp_ext << HALF_W;
            2'd3:       pp_sh = pp_ext << (2 * HALF_W);
            default:    pp_sh = pp_ext;
        endcase
    end

    assign sum = acc_q + pp_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = MUL;
`ifdef DADDA_SEQ_ZERO_SKIP_EN
                    // With a zero operand every partial product is zero, so the
                    // single hi*hi step just writes the cleared accumulator to z.
                    if (x == '0 || y == '0) step_d = 2'd3;
`endif
                end
            end
            MUL: begin
                acc_d  = sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    z_d     = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign z         = z_q;
endmodule
